// File: rtl/biriscv_csr_commit_pkg.sv
// Shared types for the CSR commit slice: exception codes, FSM states and
// the E2/WB stage payload carried between the two pipeline registers.
package biriscv_csr_commit_pkg;

    localparam int EXCEPTION_W = 6;

    localparam logic [EXCEPTION_W-1:0] EXC_NONE      = '0;
    localparam logic [EXCEPTION_W-1:0] EXC_ILLEGAL   = 6'h02;
    localparam logic [EXCEPTION_W-1:0] EXC_INTERRUPT = 6'h20;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } commit_state_t;

    typedef struct packed {
        logic                   valid;
        logic [31:0]            pc;
        logic [11:0]            csr_addr;
        logic [4:0]             rd_idx;
        logic [31:0]            value;
        logic                   write;
        logic [31:0]            wdata;
        logic [EXCEPTION_W-1:0] exception;
        logic [31:0]            addr;
    } stage_t;

endpackage

// File: rtl/biriscv_csr_commit_stage.sv
// One stall-able payload register; clear drops the valid bit and wins over stall.
module biriscv_csr_commit_stage
    import biriscv_csr_commit_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_stall,
    input  logic   i_clear,
    input  stage_t i_data,
    output stage_t o_data
);

    stage_t r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (i_clear) begin
            r_data.valid <= 1'b0;
        end else if (!i_stall) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/biriscv_csr_commit.sv
// CSR E2/WB commit: merges late memory faults and interrupts, drives the CSR
// writeback bus and owns the post-exception flush. Optional perf counters: BIRISCV_CSR_COMMIT_PERF_EN.
module biriscv_csr_commit #(
    parameter int FLUSH_TIMEOUT = 15,
    parameter int EXCEPTION_W   = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   e1_valid_i,
    input  logic [31:0]            e1_pc_i,
    input  logic [11:0]            e1_csr_addr_i,
    input  logic [4:0]             e1_rd_idx_i,
    input  logic [31:0]            csr_result_e1_value_i,
    input  logic                   csr_result_e1_write_i,
    input  logic [31:0]            csr_result_e1_wdata_i,
    input  logic [EXCEPTION_W-1:0] csr_result_e1_exception_i,
    input  logic                   mem_fault_i,
    input  logic [EXCEPTION_W-1:0] mem_exception_i,
    input  logic [31:0]            mem_addr_i,
    input  logic                   stall_i,
    input  logic                   take_interrupt_i,
    input  logic                   branch_csr_request_i,
    output logic                   csr_writeback_write_o,
    output logic [11:0]            csr_writeback_waddr_o,
    output logic [31:0]            csr_writeback_wdata_o,
    output logic [EXCEPTION_W-1:0] csr_writeback_exception_o,
    output logic [31:0]            csr_writeback_exception_pc_o,
    output logic [31:0]            csr_writeback_exception_addr_o,
    output logic                   wb_rd_valid_o,
    output logic [4:0]             wb_rd_idx_o,
    output logic [31:0]            wb_rd_value_o,
    output logic                   squash_o,
    output logic                   flush_timeout_o
`ifdef BIRISCV_CSR_COMMIT_PERF_EN
    ,
    output logic [63:0]            instret_o,
    output logic [15:0]            exc_count_o
`endif
);

    import biriscv_csr_commit_pkg::*;

    localparam logic [7:0] LP_TIMEOUT = 8'(FLUSH_TIMEOUT);

    stage_t                 w_e1_payload;
    stage_t                 w_e2;
    stage_t                 w_wb_next;
    stage_t                 w_wb;
    logic [EXCEPTION_W-1:0] w_code;
    logic                   w_commit;
    logic                   w_exc_commit;
    logic                   w_normal_commit;
    logic                   w_clear_stages;
    logic [7:0]             w_cnt_next;

    commit_state_t r_state;
    logic [7:0]    r_flush_cnt;
    logic          r_flush_timeout;

    // An illegal-instruction fault reports the opcode as its address.
    always_comb begin
        w_e1_payload           = '0;
        w_e1_payload.valid     = e1_valid_i;
        w_e1_payload.pc        = e1_pc_i;
        w_e1_payload.csr_addr  = e1_csr_addr_i;
        w_e1_payload.rd_idx    = e1_rd_idx_i;
        w_e1_payload.value     = csr_result_e1_value_i;
        w_e1_payload.write     = csr_result_e1_write_i;
        w_e1_payload.wdata     = csr_result_e1_wdata_i;
        w_e1_payload.exception = csr_result_e1_exception_i;
        w_e1_payload.addr      = (csr_result_e1_exception_i == EXC_ILLEGAL) ?
                                 csr_result_e1_value_i : 32'd0;
    end

    // The E1 exception always outranks a late LSU fault.
    always_comb begin
        w_wb_next = w_e2;
        if ((w_e2.exception == EXC_NONE) && mem_fault_i) begin
            w_wb_next.exception = mem_exception_i;
            w_wb_next.addr      = mem_addr_i;
        end
    end

    assign w_commit        = w_wb.valid && !stall_i && (r_state == ST_RUN);
    assign w_code          = (w_wb.exception != EXC_NONE) ? w_wb.exception :
                             (take_interrupt_i ? EXC_INTERRUPT : EXC_NONE);
    assign w_exc_commit    = w_commit && (w_code != EXC_NONE);
    assign w_normal_commit = w_commit && (w_code == EXC_NONE);
    assign w_clear_stages  = (r_state == ST_FLUSH) || w_exc_commit;
    assign w_cnt_next      = r_flush_cnt + 8'd1;

    biriscv_csr_commit_stage u_e2 (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_stall (stall_i),
        .i_clear (w_clear_stages),
        .i_data  (w_e1_payload),
        .o_data  (w_e2)
    );

    biriscv_csr_commit_stage u_wb (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_stall (stall_i),
        .i_clear (w_clear_stages),
        .i_data  (w_wb_next),
        .o_data  (w_wb)
    );

    // FLUSH counts every cycle regardless of stall and ends on redirect or timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= ST_RUN;
            r_flush_cnt     <= 8'd0;
            r_flush_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_exc_commit) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (branch_csr_request_i) begin
                        r_state     <= ST_RUN;
                        r_flush_cnt <= 8'd0;
                    end else if (w_cnt_next == LP_TIMEOUT) begin
                        r_state         <= ST_RUN;
                        r_flush_cnt     <= 8'd0;
                        r_flush_timeout <= 1'b1;
                    end else begin
                        r_flush_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign csr_writeback_write_o          = w_normal_commit && w_wb.write;
    assign csr_writeback_waddr_o          = w_normal_commit ? w_wb.csr_addr : 12'd0;
    assign csr_writeback_wdata_o          = w_normal_commit ? w_wb.wdata : 32'd0;
    assign csr_writeback_exception_o      = w_exc_commit ? w_code : '0;
    assign csr_writeback_exception_pc_o   = w_exc_commit ? w_wb.pc : 32'd0;
    assign csr_writeback_exception_addr_o = (w_exc_commit && (w_wb.exception != EXC_NONE)) ?
                                            w_wb.addr : 32'd0;
    assign wb_rd_valid_o                  = w_normal_commit && (w_wb.rd_idx != 5'd0);
    assign wb_rd_idx_o                    = w_normal_commit ? w_wb.rd_idx : 5'd0;
    assign wb_rd_value_o                  = w_normal_commit ? w_wb.value : 32'd0;
    assign squash_o                       = (r_state == ST_FLUSH);
    assign flush_timeout_o                = r_flush_timeout;

`ifdef BIRISCV_CSR_COMMIT_PERF_EN
    logic [63:0] r_instret;
    logic [15:0] r_exc_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_instret   <= 64'd0;
            r_exc_count <= 16'd0;
        end else begin
            if (w_normal_commit) begin
                r_instret <= r_instret + 64'd1;
            end
            if (w_exc_commit && (r_exc_count != 16'hFFFF)) begin
                r_exc_count <= r_exc_count + 16'd1;
            end
        end
    end

    assign instret_o   = r_instret;
    assign exc_count_o = r_exc_count;
`endif

endmodule

// File: tb/tb_biriscv_csr_commit.sv
// Scoreboard bench for biriscv_csr_commit: directed vectors push expected
// commits into a queue and a negedge monitor pops them as the DUT commits.
module tb_biriscv_csr_commit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        e1_valid_i;
    logic [31:0] e1_pc_i;
    logic [11:0] e1_csr_addr_i;
    logic [4:0]  e1_rd_idx_i;
    logic [31:0] csr_result_e1_value_i;
    logic        csr_result_e1_write_i;
    logic [31:0] csr_result_e1_wdata_i;
    logic [5:0]  csr_result_e1_exception_i;
    logic        mem_fault_i;
    logic [5:0]  mem_exception_i;
    logic [31:0] mem_addr_i;
    logic        stall_i;
    logic        take_interrupt_i;
    logic        branch_csr_request_i;
    logic        csr_writeback_write_o;
    logic [11:0] csr_writeback_waddr_o;
    logic [31:0] csr_writeback_wdata_o;
    logic [5:0]  csr_writeback_exception_o;
    logic [31:0] csr_writeback_exception_pc_o;
    logic [31:0] csr_writeback_exception_addr_o;
    logic        wb_rd_valid_o;
    logic [4:0]  wb_rd_idx_o;
    logic [31:0] wb_rd_value_o;
    logic        squash_o;
    logic        flush_timeout_o;
`ifdef BIRISCV_CSR_COMMIT_PERF_EN
    logic [63:0] instret_o;
    logic [15:0] exc_count_o;
`endif

    biriscv_csr_commit dut (
        .clk_i                          (clk_i),
        .rst_ni                         (rst_ni),
        .e1_valid_i                     (e1_valid_i),
        .e1_pc_i                        (e1_pc_i),
        .e1_csr_addr_i                  (e1_csr_addr_i),
        .e1_rd_idx_i                    (e1_rd_idx_i),
        .csr_result_e1_value_i          (csr_result_e1_value_i),
        .csr_result_e1_write_i          (csr_result_e1_write_i),
        .csr_result_e1_wdata_i          (csr_result_e1_wdata_i),
        .csr_result_e1_exception_i      (csr_result_e1_exception_i),
        .mem_fault_i                    (mem_fault_i),
        .mem_exception_i                (mem_exception_i),
        .mem_addr_i                     (mem_addr_i),
        .stall_i                        (stall_i),
        .take_interrupt_i               (take_interrupt_i),
        .branch_csr_request_i           (branch_csr_request_i),
        .csr_writeback_write_o          (csr_writeback_write_o),
        .csr_writeback_waddr_o          (csr_writeback_waddr_o),
        .csr_writeback_wdata_o          (csr_writeback_wdata_o),
        .csr_writeback_exception_o      (csr_writeback_exception_o),
        .csr_writeback_exception_pc_o   (csr_writeback_exception_pc_o),
        .csr_writeback_exception_addr_o (csr_writeback_exception_addr_o),
        .wb_rd_valid_o                  (wb_rd_valid_o),
        .wb_rd_idx_o                    (wb_rd_idx_o),
        .wb_rd_value_o                  (wb_rd_value_o),
        .squash_o                       (squash_o),
        .flush_timeout_o                (flush_timeout_o)
`ifdef BIRISCV_CSR_COMMIT_PERF_EN
        ,
        .instret_o                      (instret_o),
        .exc_count_o                    (exc_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        write;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [5:0]  exc;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        rdValid;
        logic [4:0]  rdIdx;
        logic [31:0] rdValue;
    } expect_t;

    expect_t expQ[$];
    int      checkCount = 0;
    int      failCount = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic expect_t mk(input logic write, input logic [11:0] waddr, input logic [31:0] wdata,
                                   input logic [5:0] exc, input logic [31:0] epc, input logic [31:0] eaddr,
                                   input logic rdValid, input logic [4:0] rdIdx, input logic [31:0] rdValue);
        expect_t e;
        e.write = write;     e.waddr = waddr;  e.wdata = wdata;
        e.exc = exc;         e.epc = epc;      e.eaddr = eaddr;
        e.rdValid = rdValid; e.rdIdx = rdIdx;  e.rdValue = rdValue;
        return e;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic waitSample();
        @(negedge clk_i);
    endtask

    // Issues one E1 instruction, optional E2 memory fault and WB interrupt; returns one cycle after the commit.
    task automatic applyStimulus(input logic [31:0] pc, input logic [11:0] addr, input logic [4:0] rd,
                                 input logic [31:0] value, input logic write, input logic [31:0] wdata,
                                 input logic [5:0] exc, input logic memFault, input logic [5:0] memExc,
                                 input logic [31:0] memAddr, input logic takeInt, input logic younger,
                                 input expect_t exp);
        expQ.push_back(exp);
        e1_valid_i = 1'b1;
        e1_pc_i = pc;
        e1_csr_addr_i = addr;
        e1_rd_idx_i = rd;
        csr_result_e1_value_i = value;
        csr_result_e1_write_i = write;
        csr_result_e1_wdata_i = wdata;
        csr_result_e1_exception_i = exc;
        step();
        if (younger) begin
            e1_pc_i = pc + 32'd4;
            e1_csr_addr_i = 12'h341;
            e1_rd_idx_i = 5'd9;
            csr_result_e1_value_i = 32'h99;
            csr_result_e1_write_i = 1'b1;
            csr_result_e1_wdata_i = 32'h77;
            csr_result_e1_exception_i = 6'h00;
        end else begin
            e1_valid_i = 1'b0;
        end
        mem_fault_i = memFault;
        mem_exception_i = memExc;
        mem_addr_i = memAddr;
        step();
        mem_fault_i = 1'b0;
        mem_exception_i = 6'h00;
        mem_addr_i = 32'd0;
        take_interrupt_i = takeInt;
        step();
        take_interrupt_i = 1'b0;
        e1_valid_i = 1'b0;
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && (csr_writeback_write_o || wb_rd_valid_o || (csr_writeback_exception_o != 6'h00))) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_commit",
                                {csr_writeback_write_o, wb_rd_valid_o, csr_writeback_exception_o}, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("csr_write", csr_writeback_write_o, e.write);
                    checkOutput("exception", csr_writeback_exception_o, e.exc);
                    checkOutput("rd_valid", wb_rd_valid_o, e.rdValid);
                    if (e.write) begin
                        checkOutput("csr_waddr", csr_writeback_waddr_o, e.waddr);
                        checkOutput("csr_wdata", csr_writeback_wdata_o, e.wdata);
                    end
                    if (e.exc != 6'h00) begin
                        checkOutput("exception_pc", csr_writeback_exception_pc_o, e.epc);
                        checkOutput("exception_addr", csr_writeback_exception_addr_o, e.eaddr);
                    end
                    if (e.rdValid) begin
                        checkOutput("rd_idx", wb_rd_idx_o, e.rdIdx);
                        checkOutput("rd_value", wb_rd_value_o, e.rdValue);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int flushCycles;
        e1_valid_i = 1'b0;
        e1_pc_i = 32'd0;
        e1_csr_addr_i = 12'd0;
        e1_rd_idx_i = 5'd0;
        csr_result_e1_value_i = 32'd0;
        csr_result_e1_write_i = 1'b0;
        csr_result_e1_wdata_i = 32'd0;
        csr_result_e1_exception_i = 6'h00;
        mem_fault_i = 1'b0;
        mem_exception_i = 6'h00;
        mem_addr_i = 32'd0;
        stall_i = 1'b0;
        take_interrupt_i = 1'b0;
        branch_csr_request_i = 1'b0;

        repeat (2) step();
        waitSample();
        checkOutput("reset_csr_write", csr_writeback_write_o, 1'b0);
        checkOutput("reset_exception", csr_writeback_exception_o, 6'h00);
        checkOutput("reset_exception_pc", csr_writeback_exception_pc_o, 32'd0);
        checkOutput("reset_rd_valid", wb_rd_valid_o, 1'b0);
        checkOutput("reset_squash", squash_o, 1'b0);
        checkOutput("reset_flush_timeout", flush_timeout_o, 1'b0);
        rst_ni = 1'b1;
        step();

        // A redirect while running must not start a flush.
        branch_csr_request_i = 1'b1;
        step();
        branch_csr_request_i = 1'b0;
        waitSample();
        checkOutput("branch_in_run_ignored", squash_o, 1'b0);

        applyStimulus(32'h1000, 12'h340, 5'd5, 32'hA5, 1'b1, 32'h1234, 6'h00, 1'b0, 6'h00, 32'd0, 1'b0, 1'b0,
                      mk(1'b1, 12'h340, 32'h1234, 6'h00, 32'd0, 32'd0, 1'b1, 5'd5, 32'hA5));
        applyStimulus(32'h1004, 12'hC00, 5'd7, 32'hDEADBEEF, 1'b0, 32'd0, 6'h00, 1'b0, 6'h00, 32'd0, 1'b0, 1'b0,
                      mk(1'b0, 12'h000, 32'd0, 6'h00, 32'd0, 32'd0, 1'b1, 5'd7, 32'hDEADBEEF));
        applyStimulus(32'h1008, 12'h305, 5'd0, 32'h11, 1'b1, 32'h8000_0000, 6'h00, 1'b0, 6'h00, 32'd0, 1'b0, 1'b0,
                      mk(1'b1, 12'h305, 32'h8000_0000, 6'h00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0));

        // Stall the instruction while it sits in WB; it must commit exactly once after release.
        expQ.push_back(mk(1'b1, 12'h341, 32'hCAFE, 6'h00, 32'd0, 32'd0, 1'b1, 5'd3, 32'h55));
        e1_valid_i = 1'b1;
        e1_pc_i = 32'h100C;
        e1_csr_addr_i = 12'h341;
        e1_rd_idx_i = 5'd3;
        csr_result_e1_value_i = 32'h55;
        csr_result_e1_write_i = 1'b1;
        csr_result_e1_wdata_i = 32'hCAFE;
        csr_result_e1_exception_i = 6'h00;
        step();
        e1_valid_i = 1'b0;
        step();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            waitSample();
            checkOutput("no_commit_during_stall", {csr_writeback_write_o, wb_rd_valid_o}, 2'b00);
            step();
        end
        stall_i = 1'b0;
        step();
        waitSample();
        checkOutput("single_commit_after_stall", wb_rd_valid_o, 1'b0);
        step();

        applyStimulus(32'h2000, 12'h340, 5'd6, 32'h77, 1'b1, 32'h1, 6'h00, 1'b1, 6'h05, 32'h8000_0004, 1'b0, 1'b0,
                      mk(1'b0, 12'h000, 32'd0, 6'h05, 32'h2000, 32'h8000_0004, 1'b0, 5'd0, 32'd0));
        waitSample();
        checkOutput("squash_after_mem_fault", squash_o, 1'b1);
        branch_csr_request_i = 1'b1;
        step();
        branch_csr_request_i = 1'b0;
        waitSample();
        checkOutput("run_after_branch_fault", squash_o, 1'b0);

        applyStimulus(32'h2004, 12'h000, 5'd8, 32'hFFFF_FFFF, 1'b0, 32'd0, 6'h02, 1'b1, 6'h05, 32'h1234, 1'b0, 1'b0,
                      mk(1'b0, 12'h000, 32'd0, 6'h02, 32'h2004, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0));
        branch_csr_request_i = 1'b1;
        step();
        branch_csr_request_i = 1'b0;
        waitSample();
        checkOutput("run_after_branch_priority", squash_o, 1'b0);

        // Interrupt with younger instructions behind it; none of them may commit.
        applyStimulus(32'h100, 12'h340, 5'd4, 32'h9, 1'b1, 32'h5, 6'h00, 1'b0, 6'h00, 32'd0, 1'b1, 1'b1,
                      mk(1'b0, 12'h000, 32'd0, 6'h20, 32'h100, 32'd0, 1'b0, 5'd0, 32'd0));
        e1_valid_i = 1'b1;
        e1_rd_idx_i = 5'd10;
        waitSample();
        checkOutput("squash_after_interrupt", squash_o, 1'b1);
        step();
        branch_csr_request_i = 1'b1;
        step();
        branch_csr_request_i = 1'b0;
        e1_valid_i = 1'b0;
        waitSample();
        checkOutput("run_after_interrupt_branch", squash_o, 1'b0);
        checkOutput("no_timeout_on_branch", flush_timeout_o, 1'b0);
        repeat (4) step();

        // Flush with no redirect: stall in the middle must not stretch it.
        applyStimulus(32'h3000, 12'h000, 5'd1, 32'h1234_5678, 1'b0, 32'd0, 6'h02, 1'b0, 6'h00, 32'd0, 1'b0, 1'b0,
                      mk(1'b0, 12'h000, 32'd0, 6'h02, 32'h3000, 32'h1234_5678, 1'b0, 5'd0, 32'd0));
        flushCycles = 0;
        for (int i = 0; i < 40; i++) begin
            waitSample();
            if (!squash_o) break;
            flushCycles++;
            stall_i = (i >= 3 && i < 7);
            step();
        end
        stall_i = 1'b0;
        checkOutput("flush_timeout_cycles", flushCycles, 15);
        checkOutput("flush_timeout_flag", flush_timeout_o, 1'b1);
        repeat (3) step();
        waitSample();
        checkOutput("flush_timeout_sticky", flush_timeout_o, 1'b1);
        checkOutput("run_after_timeout", squash_o, 1'b0);

        // Asynchronous reset in the middle of a flush.
        applyStimulus(32'h4000, 12'h340, 5'd6, 32'h1, 1'b1, 32'h2, 6'h00, 1'b1, 6'h07, 32'h44, 1'b0, 1'b0,
                      mk(1'b0, 12'h000, 32'd0, 6'h07, 32'h4000, 32'h44, 1'b0, 5'd0, 32'd0));
        waitSample();
        checkOutput("squash_before_reset", squash_o, 1'b1);
        step();
        rst_ni = 1'b0;
        #2;
        checkOutput("async_reset_squash", squash_o, 1'b0);
        checkOutput("async_reset_timeout_flag", flush_timeout_o, 1'b0);
        waitSample();
        rst_ni = 1'b1;
        step();

        applyStimulus(32'h5000, 12'h300, 5'd2, 32'h1800, 1'b1, 32'h8, 6'h00, 1'b0, 6'h00, 32'd0, 1'b0, 1'b0,
                      mk(1'b1, 12'h300, 32'h8, 6'h00, 32'd0, 32'd0, 1'b1, 5'd2, 32'h1800));
        repeat (3) step();
        waitSample();
        checkOutput("scoreboard_drained", expQ.size(), 0);
`ifdef BIRISCV_CSR_COMMIT_PERF_EN
        checkOutput("instret_after_reset", instret_o, 64'd1);
        checkOutput("exc_count_after_reset", exc_count_o, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
